video_timing_gen: RTL

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with sync, burst, active and strobe decode.
// All outputs registered (1 CK_i after the enabling edge); CK_EE_i=0 freezes everything and suppresses strobes.
module video_timing_gen #(
    parameter int C_H_TOTAL = 390,
    parameter int C_H_ACT   = 320,
    parameter int C_HS_BGN  = 340,
    parameter int C_HS_LEN  = 29,
    parameter int C_BG_BGN  = 374,
    parameter int C_BG_LEN  = 15,
    parameter int C_V_TOTAL = 262,
    parameter int C_V_ACT   = 240,
    parameter int C_VS_BGN  = 244,
    parameter int C_VS_LEN  = 3
) (
    input  logic       CK_i,
    input  logic       XARST_i,
    input  logic       CK_EE_i,
    output logic [8:0] HCTRs_o,
    output logic [7:0] VCTRs_o,
    output logic       ACTIVE_o,
    output logic       XHSYNC_o,
    output logic       XVSYNC_o,
    output logic       XCSYNC_o,
    output logic       BURST_o,
    output logic       LINE_STB_o,
    output logic       FRM_STB_o
);

    if (!((C_HS_BGN + C_HS_LEN <= C_H_TOTAL) &&
          (C_BG_BGN + C_BG_LEN <= C_H_TOTAL) &&
          (C_VS_BGN + C_VS_LEN <= C_V_TOTAL) &&
          (C_H_ACT <= C_H_TOTAL) && (C_H_TOTAL <= 512) &&
          (C_V_ACT <= C_V_TOTAL) && (C_V_TOTAL <= 256))) begin : g_bad_params
        $fatal(1, "video_timing_gen: illegal timing parameter set");
    end

    localparam logic [8:0] H_LAST = 9'(C_H_TOTAL - 1);
    localparam logic [7:0] V_LAST = 8'(C_V_TOTAL - 1);

    // Window bounds are one bit wider than the counters so an end bound of 512/256 still fits.
    localparam logic [9:0] H_ACT_E = 10'(C_H_ACT);
    localparam logic [9:0] HS_B    = 10'(C_HS_BGN);
    localparam logic [9:0] HS_E    = 10'(C_HS_BGN + C_HS_LEN);
    localparam logic [9:0] BG_B    = 10'(C_BG_BGN);
    localparam logic [9:0] BG_E    = 10'(C_BG_BGN + C_BG_LEN);
    localparam logic [8:0] V_ACT_E = 9'(C_V_ACT);
    localparam logic [8:0] VS_B    = 9'(C_VS_BGN);
    localparam logic [8:0] VS_E    = 9'(C_VS_BGN + C_VS_LEN);

    logic [8:0] h_q, h_d;
    logic [7:0] v_q, v_d;
    logic       active_q, active_d;
    logic       xhs_q, xhs_d;
    logic       xvs_q, xvs_d;
    logic       xcs_q, xcs_d;
    logic       burst_q, burst_d;
    logic       line_stb_q, line_stb_d;
    logic       frm_stb_q, frm_stb_d;

    logic [9:0] h_x;
    logic [8:0] v_x;

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        line_stb_d = 1'b0;
        frm_stb_d  = 1'b0;
        if (CK_EE_i) begin
            if (h_q == H_LAST) begin
                h_d        = 9'd0;
                line_stb_d = 1'b1;
                if (v_q == V_LAST) begin
                    v_d       = 8'd0;
                    frm_stb_d = 1'b1;
                end else begin
                    v_d = v_q + 8'd1;
                end
            end else begin
                h_d = h_q + 9'd1;
            end
        end

        // Decode from next-state counters so levels line up with the counter outputs.
        h_x      = {1'b0, h_d};
        v_x      = {1'b0, v_d};
        active_d = (h_x < H_ACT_E) && (v_x < V_ACT_E);
        xhs_d    = !((h_x >= HS_B) && (h_x < HS_E));
        xvs_d    = !((v_x >= VS_B) && (v_x < VS_E));
        xcs_d    = xvs_d ? xhs_d : !xhs_d;
        burst_d  = xvs_d && (h_x >= BG_B) && (h_x < BG_E);
    end

    always_ff @(posedge CK_i) begin
        if (!XARST_i) begin
            h_q        <= 9'd0;
            v_q        <= 8'd0;
            active_q   <= 1'b1;
            xhs_q      <= 1'b1;
            xvs_q      <= 1'b1;
            xcs_q      <= 1'b1;
            burst_q    <= 1'b0;
            line_stb_q <= 1'b0;
            frm_stb_q  <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            active_q   <= active_d;
            xhs_q      <= xhs_d;
            xvs_q      <= xvs_d;
            xcs_q      <= xcs_d;
            burst_q    <= burst_d;
            line_stb_q <= line_stb_d;
            frm_stb_q  <= frm_stb_d;
        end
    end

    assign HCTRs_o    = h_q;
    assign VCTRs_o    = v_q;
    assign ACTIVE_o   = active_q;
    assign XHSYNC_o   = xhs_q;
    assign XVSYNC_o   = xvs_q;
    assign XCSYNC_o   = xcs_q;
    assign BURST_o    = burst_q;
    assign LINE_STB_o = line_stb_q;
    assign FRM_STB_o  = frm_stb_q;

endmodule
